beat_sequencer: RTL
===================

Name: beat_sequencer

Overview:
Parametrised successor to the fixed six-beat ring counter that drives the control unit's T-states. It generates one-hot beat strobes with configurable instruction length and early instruction termination. It also provides HLT-driven halt/resume, single-step operation and a retired-instruction counter. It sits between clk/reset and the control unit, replacing the fixed beat generator.

Parameters:
NUM_T, 6, beats per full instruction cycle (>=2)
MIN_T, 3, fetch beats that always execute; early end is honoured only from beat MIN_T-1 onward (1..NUM_T)
IDX_W, $clog2(NUM_T), width of beat_idx
CNT_W, 16, width of instr_count

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
run_en  in  1  level; permits instruction cycles to start
step_mode  in  1  level; 1 = wait for step_req before each instruction
step_req  in  1  step request; internally rising-edge detected
end_early  in  1  control unit: current instruction finishes on this beat
halt  in  1  control unit: HLT decoded
resume  in  1  leave HALTED
t  out  NUM_T  one-hot beat strobes, t[0]=T0; all zero when not running
beat_idx  out  IDX_W  binary index of active beat (0 when idle)
cycle_start  out  1  high during T0
cycle_end  out  1  high on the final beat of current instruction (combinational from state and end_early)
halted  out  1  registered, high in HALTED
instr_count  out  CNT_W  instructions completed, wraps at 2^CNT_W

Behaviour:
- States: IDLE, RUN, STEP_WAIT, HALTED.
- Reset (synchronous, any state, mid-instruction included): state=IDLE, t=0, beat_idx=0, halted=0, instr_count=0, step-edge register=0.
- IDLE: t=0. When run_en=1: if step_mode=0, enter RUN at T0 on the next edge; otherwise enter STEP_WAIT.
- RUN: beat_idx advances by 1 per clk, and t = 1<<beat_idx.
- Boundary beat: beat_idx==NUM_T-1, or end_early=1 with beat_idx>=MIN_T-1.
  - end_early below MIN_T-1 is ignored.
  - cycle_end is high on the boundary beat.
  - instr_count increments on the edge leaving the boundary beat, except when leaving via halt.
- Boundary-edge priority: reset > halt > run_en=0 (to IDLE) > step_mode=1 (to STEP_WAIT) > T0 of next instruction. No dead cycle in the last case.
- halt:
  - Sampled on any beat >= MIN_T-1.
  - Acts as a boundary with priority over end_early.
  - Next edge: state=HALTED, t=0, halted=1. The halting instruction is not counted.
  - halt below MIN_T-1 is ignored.
- HALTED: holds until resume=1, then enters T0 on the next edge with halted=0. resume is ignored in other states.
- STEP_WAIT:
  - t=0.
  - A step_req rising edge (step_req=1 and previous sample 0) enters T0 on the next edge.
  - A held step_req starts only one instruction.
  - run_en=0 returns to IDLE. Clearing step_mode starts T0 on the next edge.
- run_en falling mid-instruction: the instruction completes, then IDLE.
- step_mode changes take effect only at a boundary.
- Invariant: t is one-hot in RUN and zero otherwise.

Decomposition:
- Shared timing package/header: state encoding localparams (S_IDLE, S_RUN, S_STEP_WAIT, S_HALTED) and default NUM_T/MIN_T constants, reused by the control unit.
- No sub-module. One-hot decode of beat_idx and step edge detection stay inline.

Test Plan:
All scenarios use NUM_T=6, MIN_T=3.
- Free run: reset 1 cycle, then run_en=1 -> t walks 000001..100000, repeats with no gap; instr_count=3 after 18 beats.
- Early end: end_early=1 during T3 -> next beat T0 (4-beat instruction), cycle_end high at T3, count +1. end_early during T1 -> ignored, 6 beats.
- Halt/resume: halt=1 at T4 -> next edge t=0, halted=1, count unchanged; resume after 5 cycles -> T0 next edge, halted=0.
- Single step: step_mode=1, step_req held high 20 cycles -> exactly one 6-beat instruction, then STEP_WAIT; second rising edge -> one more; count=2.
- run_en drop at T2 -> T3..T5 complete, then IDLE with t=0; count +1.
- Reset at T4 mid-instruction, and reset while HALTED -> next edge t=0, beat_idx=0, halted=0, instr_count=0, state IDLE.

Source files
------------

// File: rtl/beat_sequencer_pkg.sv
// Shared timing definitions for the beat sequencer and the control unit that
// consumes its T-state strobes.
package beat_sequencer_pkg;

  localparam int DEF_NUM_T = 6;
  localparam int DEF_MIN_T = 3;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_IDX_W = $clog2(DEF_NUM_T);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_STEP_WAIT = 2'd2,
    S_HALTED    = 2'd3
  } seq_state_e;

  // Early end and halt are honoured only once the fixed fetch beats are done.
  function automatic logic past_fetch(input int beat, input int min_t);
    return beat >= (min_t - 1);
  endfunction

endpackage : beat_sequencer_pkg

// File: rtl/beat_sequencer_if.sv
// Control-unit <-> beat sequencer bundle: run/step/halt requests in, beat
// strobes, status and retired-instruction count out.
interface beat_sequencer_if
  import beat_sequencer_pkg::*;
#(
  parameter int NUM_T = DEF_NUM_T,
  parameter int IDX_W = $clog2(NUM_T),
  parameter int CNT_W = DEF_CNT_W
);

  logic             run_en;
  logic             step_mode;
  logic             step_req;
  logic             end_early;
  logic             halt;
  logic             resume;

  logic [NUM_T-1:0] t;
  logic [IDX_W-1:0] beat_idx;
  logic             cycle_start;
  logic             cycle_end;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  // Control-unit side.
  modport master (
    output run_en, step_mode, step_req, end_early, halt, resume,
    input  t, beat_idx, cycle_start, cycle_end, halted, instr_count
  );

  // Sequencer side.
  modport slave (
    input  run_en, step_mode, step_req, end_early, halt, resume,
    output t, beat_idx, cycle_start, cycle_end, halted, instr_count
  );

endinterface : beat_sequencer_if

// File: rtl/beat_sequencer.sv
// One-hot T-state generator with variable instruction length, halt/resume,
// single-step and a retired-instruction counter.
module beat_sequencer
  import beat_sequencer_pkg::*;
#(
  parameter int NUM_T = DEF_NUM_T,
  parameter int MIN_T = DEF_MIN_T,
  parameter int IDX_W = $clog2(NUM_T),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  beat_sequencer_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_BEAT  = IDX_W'(NUM_T - 1);
  localparam logic [NUM_T-1:0] BEAT0_MASK = NUM_T'(1);

  seq_state_e       r_state;
  logic [IDX_W-1:0] r_beat;
  logic [CNT_W-1:0] r_count;
  logic             r_halted;
  logic             r_step_prev;

  seq_state_e       w_state_nxt;
  logic [IDX_W-1:0] w_beat_nxt;
  logic             w_count_inc;

  logic             w_running;
  logic             w_late;
  logic             w_last;
  logic             w_halt_hit;
  logic             w_boundary;
  logic             w_step_rise;

  assign w_running   = (r_state == S_RUN);
  assign w_late      = past_fetch(int'(r_beat), MIN_T);
  assign w_last      = (r_beat == LAST_BEAT);
  assign w_halt_hit  = w_running && bus.halt && w_late;
  assign w_boundary  = w_running && (w_last || (bus.end_early && w_late) || bus.halt && w_late);
  assign w_step_rise = bus.step_req && !r_step_prev;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_count_inc = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.run_en) begin
          w_state_nxt = bus.step_mode ? S_STEP_WAIT : S_RUN;
        end
      end

      S_RUN: begin
        if (w_boundary) begin
          w_beat_nxt = '0;
          if (w_halt_hit) begin
            w_state_nxt = S_HALTED;
          end else begin
            w_count_inc = 1'b1;
            if (!bus.run_en) begin
              w_state_nxt = S_IDLE;
            end else if (bus.step_mode) begin
              w_state_nxt = S_STEP_WAIT;
            end else begin
              w_state_nxt = S_RUN;
            end
          end
        end else begin
          w_beat_nxt = r_beat + IDX_W'(1);
        end
      end

      S_STEP_WAIT: begin
        if (!bus.run_en) begin
          w_state_nxt = S_IDLE;
        end else if (!bus.step_mode || w_step_rise) begin
          w_state_nxt = S_RUN;
        end
      end

      S_HALTED: begin
        if (bus.resume) begin
          w_state_nxt = S_RUN;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_beat_nxt  = '0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_count     <= '0;
      r_halted    <= 1'b0;
      r_step_prev <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat      <= w_beat_nxt;
      r_halted    <= (w_state_nxt == S_HALTED);
      r_step_prev <= bus.step_req;
      if (w_count_inc) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // r_beat is forced to zero on every exit from RUN, so it reads 0 when idle.
  assign bus.t           = w_running ? (BEAT0_MASK << r_beat) : '0;
  assign bus.beat_idx    = r_beat;
  assign bus.cycle_start = w_running && (r_beat == '0);
  assign bus.cycle_end   = w_boundary;
  assign bus.halted      = r_halted;
  assign bus.instr_count = r_count;

  a_onehot_in_run : assert property (@(posedge clk) disable iff (reset)
    w_running |-> $onehot(bus.t));

  a_zero_outside_run : assert property (@(posedge clk) disable iff (reset)
    !w_running |-> (bus.t == '0));

endmodule : beat_sequencer
